// File: rtl/avr_pkg.sv
// Shared definitions for the AVR program-memory loader.
package avr_pkg;

    // Loader FSM states: frame header, data word assembly, write strobe and checksum.
    typedef enum logic [2:0] {
        LD_IDLE,
        LD_ADDR_H,
        LD_ADDR_L,
        LD_LEN,
        LD_DATA_H,
        LD_DATA_L,
        LD_WRITE,
        LD_CSUM
    } loader_state_t;

    localparam logic [1:0] LOADER_ERR_NONE    = 2'b00;
    localparam logic [1:0] LOADER_ERR_CSUM    = 2'b01;
    localparam logic [1:0] LOADER_ERR_TIMEOUT = 2'b10;

    localparam logic [7:0] LOADER_SYNC_BYTE   = 8'hA5;

endpackage

// File: rtl/avr_prog_loader.sv
// Program-memory loader: parses SYNC/ADDR/LEN/data/CSUM frames from a byte
// stream, writes 16-bit words into program memory and holds the CPU in reset
// until a frame with a good checksum completes.
// Optional inter-byte timeout: define AVR_LOADER_TIMEOUT_EN.
module avr_prog_loader
    import avr_pkg::*;
#(
    parameter int         PM_AW       = 16,
    parameter logic [7:0] SYNC_BYTE   = LOADER_SYNC_BYTE,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [PM_AW-1:0] pm_addr,
    output logic [15:0]      pm_wdata,
    output logic             pm_we,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("avr_prog_loader: TIMEOUT_CYC must be at least 2");
    end

    loader_state_t state, state_n;

    logic             acc;
    logic             to_fire;
    logic [7:0]       addr_h;
    logic [7:0]       sum;
    logic [7:0]       sum_n;
    logic [8:0]       cnt;      // words left in the frame, 1..256
    logic [PM_AW-1:0] waddr;

    assign acc   = rx_valid & rx_ready;
    assign sum_n = sum + rx_data;

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= LD_IDLE;
        else      state <= state_n;
    end

    // Next-state and handshake/strobe decode.
    always_comb begin
        state_n  = state;
        rx_ready = (state != LD_WRITE);
        pm_we    = (state == LD_WRITE);
        busy     = (state != LD_IDLE);
        if (to_fire) begin
            state_n = LD_IDLE;
        end else begin
            case (state)
                LD_IDLE:   if (acc && rx_data == SYNC_BYTE) state_n = LD_ADDR_H;
                LD_ADDR_H: if (acc) state_n = LD_ADDR_L;
                LD_ADDR_L: if (acc) state_n = LD_LEN;
                LD_LEN:    if (acc) state_n = LD_DATA_H;
                LD_DATA_H: if (acc) state_n = LD_DATA_L;
                LD_DATA_L: if (acc) state_n = LD_WRITE;
                LD_WRITE:  state_n = (cnt == 9'd1) ? LD_CSUM : LD_DATA_H;
                LD_CSUM:   if (acc) state_n = LD_IDLE;
                default:   state_n = LD_IDLE;
            endcase
        end
    end

    // Frame datapath: address, word assembly, running checksum and status.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addr_h   <= '0;
            sum      <= '0;
            cnt      <= '0;
            waddr    <= '0;
            pm_wdata <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= LOADER_ERR_NONE;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (acc) begin
                case (state)
                    LD_IDLE:   if (rx_data == SYNC_BYTE) cpu_hold <= 1'b1;
                    LD_ADDR_H: begin
                        addr_h <= rx_data;
                        sum    <= rx_data;
                    end
                    LD_ADDR_L: begin
                        waddr <= PM_AW'({addr_h, rx_data});
                        sum   <= sum_n;
                    end
                    LD_LEN: begin
                        cnt <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        sum <= sum_n;
                    end
                    LD_DATA_H: begin
                        pm_wdata[15:8] <= rx_data;
                        sum            <= sum_n;
                    end
                    LD_DATA_L: begin
                        pm_wdata[7:0] <= rx_data;
                        sum           <= sum_n;
                    end
                    LD_CSUM: begin
                        if (sum_n == 8'h00) begin
                            done     <= 1'b1;
                            err_code <= LOADER_ERR_NONE;
                            cpu_hold <= 1'b0;
                        end else begin
                            err      <= 1'b1;
                            err_code <= LOADER_ERR_CSUM;
                        end
                    end
                    default: ;
                endcase
            end
            // Address and word count step once per issued write.
            if (state == LD_WRITE) begin
                waddr <= waddr + PM_AW'(1);
                cnt   <= cnt - 9'd1;
            end
            if (to_fire) begin
                err      <= 1'b1;
                err_code <= LOADER_ERR_TIMEOUT;
            end
        end
    end

    assign pm_addr = waddr;

`ifdef AVR_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;
    logic            counting;

    // Frozen during the write cycle, parked at zero while idle.
    assign counting = (state != LD_IDLE) && (state != LD_WRITE);
    // An accepted byte in the same cycle always wins over the expiry.
    assign to_fire  = counting && !acc && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Inter-byte idle counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                          to_cnt <= '0;
        else if (acc || state == LD_IDLE)  to_cnt <= '0;
        else if (counting)                 to_cnt <= to_cnt + TO_W'(1);
    end
`else
    assign to_fire = 1'b0;
`endif

endmodule

// File: tb/tb_avr_prog_loader.sv
// Self-checking bench for avr_prog_loader: expected writes and frame outcomes
// are queued as frames are sent and popped when the DUT strobes them.
`timescale 1ns/1ps
module tb_avr_prog_loader;

    localparam int PM_AW = 16;
    localparam int T_CYC = 40;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic             rx_ready;
    logic [PM_AW-1:0] pm_addr;
    logic [15:0]      pm_wdata;
    logic             pm_we;
    logic             cpu_hold;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;

    avr_prog_loader #(.PM_AW(PM_AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(T_CYC)) dut (
        .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .pm_addr(pm_addr), .pm_wdata(pm_wdata), .pm_we(pm_we), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad = 0;
    int          nwr = 0;
    int          gap = 0;
    logic [31:0] wq[$];      // {addr, data}
    logic [2:0]  rq[$];      // {is_err, err_code}
    logic [15:0] fw[$];      // words of the next frame
    logic [31:0] we_e;
    logic [2:0]  r_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare every write strobe and frame-end pulse.
    always @(negedge CLK) begin
        if (RST) begin
            if (pm_we) begin
                nwr++;
                if (wq.size() == 0) chk("we_q_size", wq.size(), 1);
                else begin
                    we_e = wq.pop_front();
                    chk("we_addr", {16'h0, pm_addr}, {16'h0, we_e[31:16]});
                    chk("we_data", {16'h0, pm_wdata}, {16'h0, we_e[15:0]});
                end
            end
            if (done || err) begin
                if (rq.size() == 0) chk("evt_q_size", rq.size(), 1);
                else begin
                    r_e = rq.pop_front();
                    chk("done", {31'h0, done}, {31'h0, ~r_e[2]});
                    chk("err", {31'h0, err}, {31'h0, r_e[2]});
                    chk("err_code", {30'h0, err_code}, {30'h0, r_e[1:0]});
                    chk("cpu_hold_end", {31'h0, cpu_hold}, {31'h0, r_e[2]});
                    chk("busy_end", {31'h0, busy}, 0);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge CLK);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!rx_ready) chk("rx_ready_wait", {31'h0, rx_ready}, 1);
        else @(posedge CLK);
    endtask

    task automatic pause(input int g);
        @(negedge CLK);
        rx_valid = 1'b0;
        repeat (g) @(negedge CLK);
    endtask

    task automatic sb(input logic [7:0] b);
        send_byte(b);
        if (gap > 0) pause(gap);
    endtask

    task automatic send_frame(input logic [15:0] addr, input logic [7:0] len, input bit bad_cs);
        logic [7:0]  s;
        logic [15:0] a;
        int          nw;
        nw = (len == 8'h00) ? 256 : int'(len);
        s  = addr[15:8] + addr[7:0] + len;
        a  = addr;
        for (int i = 0; i < nw; i++) begin
            s = s + fw[i][15:8] + fw[i][7:0];
            wq.push_back({a, fw[i]});
            a = a + 16'd1;
        end
        rq.push_back(bad_cs ? 3'b101 : 3'b000);
        send_byte(8'hA5);
        #1;
        chk("hold_after_sync", {31'h0, cpu_hold}, 1);
        chk("busy_after_sync", {31'h0, busy}, 1);
        if (gap > 0) pause(gap);
        sb(addr[15:8]);
        sb(addr[7:0]);
        sb(len);
        for (int i = 0; i < nw; i++) begin
            sb(fw[i][15:8]);
            sb(fw[i][7:0]);
        end
        s = 8'h00 - s;
        if (bad_cs) s = s + 8'h01;
        sb(s);
        pause(1);
        chk("done_one_cycle", {31'h0, done}, 0);
        chk("err_one_cycle", {31'h0, err}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        repeat (3) @(negedge CLK);
        chk("rst_rx_ready", {31'h0, rx_ready}, 1);
        chk("rst_pm_we", {31'h0, pm_we}, 0);
        chk("rst_pm_addr", {16'h0, pm_addr}, 0);
        chk("rst_pm_wdata", {16'h0, pm_wdata}, 0);
        chk("rst_cpu_hold", {31'h0, cpu_hold}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done_err", {30'h0, done, err}, 0);
        chk("rst_err_code", {30'h0, err_code}, 0);
        RST = 1'b1;

        // Basic two-word frame.
        fw = '{16'h0C94, 16'h3412};
        send_frame(16'h0010, 8'h02, 1'b0);
        chk("t1_hold", {31'h0, cpu_hold}, 0);
        chk("t1_code", {30'h0, err_code}, 0);

        // Bad checksum: writes still land, CPU stays held, code sticks.
        send_frame(16'h0010, 8'h02, 1'b1);
        chk("t2_hold", {31'h0, cpu_hold}, 1);
        pause(3);
        chk("t2_code_holds", {30'h0, err_code}, 1);
        send_frame(16'h0010, 8'h02, 1'b0);
        chk("t2_hold_released", {31'h0, cpu_hold}, 0);
        chk("t2_code_cleared", {30'h0, err_code}, 0);

        // Junk before SYNC is dropped silently.
        n0 = nwr;
        send_byte(8'h00); #1 chk("t3_busy_00", {31'h0, busy}, 0);
        send_byte(8'hFF); #1 chk("t3_busy_ff", {31'h0, busy}, 0);
        send_byte(8'h3C); #1 chk("t3_busy_3c", {31'h0, busy}, 0);
        pause(2);
        chk("t3_no_writes", nwr - n0, 0);
        fw = '{16'hA5A5, 16'h00FF};
        send_frame(16'h0200, 8'h02, 1'b0);

        // Address wrap and LEN 0 = 256 words.
        fw = '{16'hBEEF, 16'hCAFE};
        send_frame(16'hFFFF, 8'h02, 1'b0);
        fw.delete();
        for (int i = 0; i < 256; i++) fw.push_back(16'($urandom));
        n0 = nwr;
        send_frame(16'h1234, 8'h00, 1'b0);
        chk("t4_n256", nwr - n0, 256);

        // Reset mid-frame.
        wq.push_back({16'h0040, 16'hA511});
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h40);
        send_byte(8'h04);
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        #2;
        rx_valid = 1'b0;
        RST = 1'b0;
        #1;
        chk("t5_rx_ready", {31'h0, rx_ready}, 1);
        chk("t5_pm_we", {31'h0, pm_we}, 0);
        chk("t5_pm_addr", {16'h0, pm_addr}, 0);
        chk("t5_pm_wdata", {16'h0, pm_wdata}, 0);
        chk("t5_cpu_hold", {31'h0, cpu_hold}, 0);
        chk("t5_busy", {31'h0, busy}, 0);
        chk("t5_err_code", {30'h0, err_code}, 0);
        chk("t5_partial_write", wq.size(), 0);
        @(negedge CLK);
        RST = 1'b1;
        fw = '{16'h1357, 16'h2468, 16'h9ABC};
        send_frame(16'h0100, 8'h03, 1'b0);

`ifdef AVR_LOADER_TIMEOUT_EN
        // Stall after LEN until the timeout fires.
        rq.push_back(3'b110);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h01);
        pause(T_CYC - 3);
        chk("t6_not_early", rq.size(), 1);
        chk("t6_busy_before", {31'h0, busy}, 1);
        repeat (5) @(negedge CLK);
        chk("t6_fired", rq.size(), 0);
        chk("t6_idle", {31'h0, busy}, 0);
        chk("t6_code", {30'h0, err_code}, 2);
        chk("t6_hold", {31'h0, cpu_hold}, 1);

        // Gaps one short of the timeout complete normally.
        gap = T_CYC - 2;
        fw = '{16'h5A5A, 16'h0102};
        send_frame(16'h0300, 8'h02, 1'b0);
        gap = 0;
        chk("t6_gap_hold", {31'h0, cpu_hold}, 0);
`endif

        pause(5);
        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
